eth_tx_framer: RTL

- Transmit-side counterpart of the RX MAC-address frame filter.
- Takes a raw 8-bit AXI-Stream payload and prepends a 14-byte Ethernet II header: destination MAC, source MAC, then EtherType.
- Pads short frames to the Ethernet minimum length and forwards the result to the TX AXIS port of the RGMII MAC, which appends the FCS.
- Counts successfully framed packets for the register file.

---
 rtl/eth_tx_framer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/eth_tx_framer.sv
// ============================================================================
//  Module      : eth_tx_framer
//  Description : Prepends a 14-byte Ethernet II header to an AXIS payload,
//                pads short frames to the minimum length, counts sent frames.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_tx_framer #(
    parameter int unsigned MIN_FRAME_LEN = 60,
    parameter logic [7:0]  PAD_BYTE      = 8'h00,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [47:0]          dst_mac_i,
    input  logic [47:0]          src_mac_i,
    input  logic [15:0]          ethertype_i,
    input  logic [7:0]           s_tdata_i,
    input  logic                 s_tvalid_i,
    output logic                 s_tready_o,
    input  logic                 s_tlast_i,
    input  logic                 s_tuser_i,
    output logic [7:0]           m_tdata_o,
    output logic                 m_tvalid_o,
    input  logic                 m_tready_i,
    output logic                 m_tlast_o,
    output logic                 m_tuser_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] frames_sent_o
);

    localparam logic [1:0]  c_ST_IDLE    = 2'd0;
    localparam logic [1:0]  c_ST_HDR     = 2'd1;
    localparam logic [1:0]  c_ST_PAYLOAD = 2'd2;
    localparam logic [1:0]  c_ST_PAD     = 2'd3;
    localparam logic [10:0] c_CNT_MAX    = 11'd2047;
    localparam logic [10:0] c_HDR_LAST   = 11'd13;
    localparam logic [11:0] c_MIN_LEN    = 12'(MIN_FRAME_LEN);
    localparam logic [10:0] c_PAD_LAST   = 11'(MIN_FRAME_LEN - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [10:0]          r_cnt;
    logic [111:0]         r_hdr;
    logic [CNT_WIDTH-1:0] r_frames;

    logic [11:0] w_cnt_inc;
    logic        w_len_ok;
    logic        w_m_hs;
    logic        w_frame_done;

    assign w_cnt_inc = {1'b0, r_cnt} + 12'd1;
    assign w_len_ok  = (w_cnt_inc >= c_MIN_LEN);
    assign w_m_hs    = m_tvalid_o && m_tready_i;

    // A frame counts as sent only when its final, non-aborted byte is accepted.
    assign w_frame_done = w_m_hs && m_tlast_o &&
                          (((r_state == c_ST_PAYLOAD) && !s_tuser_i) ||
                           (r_state == c_ST_PAD));

    assign frames_sent_o = r_frames;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (s_tvalid_i) w_state_nxt = c_ST_HDR;
            end
            c_ST_HDR: begin
                if (w_m_hs && (r_cnt == c_HDR_LAST)) w_state_nxt = c_ST_PAYLOAD;
            end
            c_ST_PAYLOAD: begin
                if (w_m_hs && s_tlast_i) begin
                    w_state_nxt = (s_tuser_i || w_len_ok) ? c_ST_IDLE : c_ST_PAD;
                end
            end
            default: begin
                if (w_m_hs && m_tlast_o) w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s_tready_o = 1'b0;
        m_tvalid_o = 1'b0;
        m_tdata_o  = 8'h00;
        m_tlast_o  = 1'b0;
        m_tuser_o  = 1'b0;
        busy_o     = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_HDR: begin
                m_tvalid_o = 1'b1;
                m_tdata_o  = r_hdr[111:104];
            end
            c_ST_PAYLOAD: begin
                m_tvalid_o = s_tvalid_i;
                s_tready_o = m_tready_i;
                m_tdata_o  = s_tdata_i;
                m_tuser_o  = s_tuser_i;
                m_tlast_o  = s_tlast_i && (s_tuser_i || w_len_ok);
            end
            c_ST_PAD: begin
                m_tvalid_o = 1'b1;
                m_tdata_o  = PAD_BYTE;
                m_tlast_o  = (r_cnt == c_PAD_LAST);
            end
            default: ;
        endcase
    end

    // Header is held as a shift register so the outgoing byte is always the top octet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= 11'd0;
            r_hdr <= 112'd0;
        end else if ((r_state == c_ST_IDLE) && s_tvalid_i) begin
            r_cnt <= 11'd0;
            r_hdr <= {dst_mac_i, src_mac_i, ethertype_i};
        end else if (w_m_hs) begin
            if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + 11'd1;
            if (r_state == c_ST_HDR) r_hdr <= {r_hdr[103:0], 8'h00};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frames <= '0;
        end else if (w_frame_done) begin
            r_frames <= r_frames + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire
